store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Store-side counterpart of the memory-access load/writeback path: accepts store requests from the execute stage and produces byte-lane write-enables plus lane-replicated write data.
- Queues aligned stores in a small FIFO and drains them to data memory over a valid/ready handshake.
- Flags misaligned or illegal stores.
- Reports a word-address hazard so the load path can stall while a matching store is still pending.

Parameters:
- DEPTH, 4, number of store entries; power of two, minimum 2
- AW, 14, data-memory word-address width

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- st_valid  input  1  execute stage presents a store
- st_ready  output  1  buffer can accept a store this cycle
- st_addr  input  32  byte address (ALU result)
- st_data  input  32  rs2 value, unaligned
- st_sel  input  2  00=SB, 01=SH, 10=SW, 11=illegal
- st_misaligned  output  1  one-cycle registered pulse: last accepted store was dropped
- dmem_valid  output  1  head entry valid toward data memory
- dmem_ready  input  1  data memory accepts the head entry
- dmem_addr  output  AW  word address of head entry
- dmem_we  output  4  byte-lane write-enable of head entry
- dmem_din  output  32  lane-replicated write data of head entry
- ld_addr  input  32  byte address of the load in memory stage
- ld_hazard  output  1  combinational: some valid entry has word address ld_addr[AW+1:2]
- count  output  log2(DEPTH)+1  entries currently held
- empty  output  1  count==0

Behaviour:
- Reset, asynchronous on rst_n low:
  - write pointer, read pointer and count clear to 0.
  - st_misaligned=0, dmem_valid=0.
  - All entry valid bits clear.
  - dmem_we reads 0; dmem_addr and dmem_din read 0.
  - Reset asserted mid-drain discards every pending entry; no partial write is emitted after release.
- Accept:
  - st_ready = (count != DEPTH).
  - st_ready depends only on registered state, with no combinational path from dmem_ready.
  - A store is accepted when st_valid && st_ready.
- Alignment and lane formatting at accept:
  - SB: we = 4'b0001 << addr[1:0]; din = {4{data[7:0]}}.
  - SH: addr[0] must be 0. we = addr[1] ? 4'b1100 : 4'b0011; din = {2{data[15:0]}}.
  - SW: addr[1:0] must be 00. we = 4'b1111; din = data.
  - Entry word address = st_addr[AW+1:2]; upper address bits are ignored.
- Misaligned or illegal store (SH with addr[0]=1, SW with addr[1:0]!=0, or st_sel=11):
  - The handshake still completes, but nothing is enqueued.
  - st_misaligned is 1 for exactly the cycle after acceptance, otherwise 0.
- Drain:
  - Head entry is driven from storage at the read pointer.
  - dmem_valid = (count != 0).
  - Pop on dmem_valid && dmem_ready.
  - dmem_valid must stay high, with addr/we/din stable, until popped.
  - dmem_we is forced to 0 whenever dmem_valid=0.
- Latency: a store accepted at edge N is presented (dmem_valid=1) after edge N when the buffer was empty, i.e. in cycle N+1.
- Simultaneous accept and pop:
  - Count is unchanged; both pointers advance.
  - When full, no accept occurs (st_ready=0) even if a pop happens the same cycle.
- Pointers wrap modulo DEPTH. Full = count==DEPTH; empty = count==0. Count never exceeds DEPTH or underflows.
- Stores drain strictly in program (acceptance) order.
- ld_hazard:
  - Compares every valid entry, including the head, against ld_addr[AW+1:2].
  - It does not consider a store being accepted in the same cycle.
  - An entry popped this cycle still counts toward hazard in this cycle.

Test Plan:
- Reset then SB to 0x0000_0013 with data 0x1234_56AB, dmem_ready=1 -> next cycle dmem_valid=1, dmem_addr=4, dmem_we=4'b1000, dmem_din=0xABABABAB; pops and empty=1 the following cycle.
- SH to 0x102 with data 0xDEAD_BEEF, then SW to 0x104 with data 0xCAFEF00D -> entries {addr 0x40, we 1100, din 0xBEEFBEEF} then {addr 0x41, we 1111, din 0xCAFEF00D}, in order.
- dmem_ready held 0, five SW stores issued with DEPTH=4 -> st_ready drops after the 4th (count=4); 5th held until one pop; outputs stay stable while stalled.
- SW to 0x0000_0006 and st_sel=11 -> both handshakes complete; st_misaligned pulses 1 for one cycle each; count stays 0; dmem_valid stays 0.
- Pending SB to 0x201, ld_addr=0x203 -> ld_hazard=1; ld_addr=0x204 -> 0; after the pop ld_hazard=0.
- Three entries queued, rst_n pulsed low mid-drain -> outputs immediately 0/empty; after release no dmem_valid until a new store is accepted.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: queues aligned stores from execute and drains them to data
// memory in acceptance order over a valid/ready handshake. Formats byte-lane
// write-enables and lane-replicated data at accept, flags misaligned/illegal
// stores, and reports a word-address hazard against pending entries.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 14
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  input  logic [1:0]               st_sel,
  output logic                     st_misaligned,
  output logic                     dmem_valid,
  input  logic                     dmem_ready,
  output logic [AW-1:0]            dmem_addr,
  output logic [3:0]               dmem_we,
  output logic [31:0]              dmem_din,
  input  logic [31:0]              ld_addr,
  output logic                     ld_hazard,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             misal_q, misal_d;
  logic [DEPTH-1:0] ent_vld_q, ent_vld_d;
  logic [AW-1:0]    ent_addr_q [DEPTH];
  logic [AW-1:0]    ent_addr_d [DEPTH];
  logic [3:0]       ent_we_q   [DEPTH];
  logic [3:0]       ent_we_d   [DEPTH];
  logic [31:0]      ent_din_q  [DEPTH];
  logic [31:0]      ent_din_d  [DEPTH];

  logic        fmt_bad;
  logic [3:0]  fmt_we;
  logic [31:0] fmt_din;
  logic        accept, push, pop;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{st_addr[31:AW+2], ld_addr[31:AW+2], ld_addr[1:0]};

  // Ready and head-valid come from registered count only.
  assign st_ready   = (count_q != CW'(DEPTH));
  assign dmem_valid = (count_q != '0);
  assign accept     = st_valid && st_ready;
  assign push       = accept && !fmt_bad;
  assign pop        = dmem_valid && dmem_ready;

  assign count         = count_q;
  assign empty         = (count_q == '0);
  assign st_misaligned = misal_q;

  // Head entry is gated to zero whenever nothing is presented.
  assign dmem_addr = dmem_valid ? ent_addr_q[rd_ptr_q] : '0;
  assign dmem_we   = dmem_valid ? ent_we_q[rd_ptr_q]   : '0;
  assign dmem_din  = dmem_valid ? ent_din_q[rd_ptr_q]  : '0;

  // Lane formatting and alignment check of the incoming store.
  always_comb begin
    fmt_bad = 1'b0;
    fmt_we  = '0;
    fmt_din = '0;
    case (st_sel)
      2'b00: begin
        fmt_we  = 4'b0001 << st_addr[1:0];
        fmt_din = {4{st_data[7:0]}};
      end
      2'b01: begin
        fmt_bad = st_addr[0];
        fmt_we  = st_addr[1] ? 4'b1100 : 4'b0011;
        fmt_din = {2{st_data[15:0]}};
      end
      2'b10: begin
        fmt_bad = |st_addr[1:0];
        fmt_we  = 4'b1111;
        fmt_din = st_data;
      end
      default: fmt_bad = 1'b1;
    endcase
  end

  // Word-address hazard against every valid entry, head included.
  always_comb begin
    ld_hazard = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_vld_q[i] && (ent_addr_q[i] == ld_addr[AW+1:2])) ld_hazard = 1'b1;
    end
  end

  // Next-state for pointers, count, misaligned pulse and entry storage.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    misal_d    = accept && fmt_bad;
    ent_vld_d  = ent_vld_q;
    ent_addr_d = ent_addr_q;
    ent_we_d   = ent_we_q;
    ent_din_d  = ent_din_q;
    // Pop clears before push sets; indices only coincide when empty or full,
    // where one of the two cannot happen.
    if (pop) begin
      ent_vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d            = PW'(rd_ptr_q + 1'b1);
    end
    if (push) begin
      ent_vld_d[wr_ptr_q]  = 1'b1;
      ent_addr_d[wr_ptr_q] = st_addr[AW+1:2];
      ent_we_d[wr_ptr_q]   = fmt_we;
      ent_din_d[wr_ptr_q]  = fmt_din;
      wr_ptr_d             = PW'(wr_ptr_q + 1'b1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      misal_q   <= 1'b0;
      ent_vld_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_addr_q[i] <= '0;
        ent_we_q[i]   <= '0;
        ent_din_q[i]  <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      misal_q    <= misal_d;
      ent_vld_q  <= ent_vld_d;
      ent_addr_q <= ent_addr_d;
      ent_we_q   <= ent_we_d;
      ent_din_q  <= ent_din_d;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a queue-based model.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          st_valid = 1'b0;
  logic          st_ready;
  logic [31:0]   st_addr = '0;
  logic [31:0]   st_data = '0;
  logic [1:0]    st_sel = '0;
  logic          st_misaligned;
  logic          dmem_valid;
  logic          dmem_ready = 1'b0;
  logic [AW-1:0] dmem_addr;
  logic [3:0]    dmem_we;
  logic [31:0]   dmem_din;
  logic [31:0]   ld_addr = '0;
  logic          ld_hazard;
  logic [2:0]    count;
  logic          empty;

  store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_sel(st_sel), .st_misaligned(st_misaligned),
    .dmem_valid(dmem_valid), .dmem_ready(dmem_ready), .dmem_addr(dmem_addr),
    .dmem_we(dmem_we), .dmem_din(dmem_din), .ld_addr(ld_addr),
    .ld_hazard(ld_hazard), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [3:0]    we;
    logic [31:0]   d;
  } ent_t;

  ent_t model_q[$];
  logic misal_exp = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // What a store must become, straight from the lane rules.
  function automatic void fmt(input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] s, output logic bad, output ent_t e);
    int unsigned sh;
    bad  = 1'b0;
    e.a  = a[AW+1:2];
    e.we = 4'h0;
    e.d  = 32'h0;
    sh   = a % 4;
    case (s)
      2'd0: begin e.we = 4'(1 << sh); e.d = {24'h0, d[7:0]} * 32'h0101_0101; end
      2'd1: begin bad = a[0]; e.we = (sh >= 2) ? 4'hC : 4'h3; e.d = {16'h0, d[15:0]} * 32'h0001_0001; end
      2'd2: begin bad = (sh != 0); e.we = 4'hF; e.d = d; end
      default: bad = 1'b1;
    endcase
  endfunction

  // Compare process: checks all outputs each cycle, then advances the model.
  always begin
    logic exp_h, acc, pop, bad;
    ent_t e;
    @(negedge clk);
    #2;
    if (!rst_n) begin
      model_q.delete();
      misal_exp = 1'b0;
    end
    exp_h = 1'b0;
    foreach (model_q[i]) if (model_q[i].a == ld_addr[AW+1:2]) exp_h = 1'b1;
    cmp("st_ready", 32'(st_ready), 32'(model_q.size() != DEPTH));
    cmp("count", 32'(count), 32'(model_q.size()));
    cmp("empty", 32'(empty), 32'(model_q.size() == 0));
    cmp("dmem_valid", 32'(dmem_valid), 32'(model_q.size() != 0));
    cmp("st_misaligned", 32'(st_misaligned), 32'(misal_exp));
    cmp("ld_hazard", 32'(ld_hazard), 32'(exp_h));
    if (model_q.size() != 0) begin
      cmp("dmem_addr", 32'(dmem_addr), 32'(model_q[0].a));
      cmp("dmem_we", 32'(dmem_we), 32'(model_q[0].we));
      cmp("dmem_din", dmem_din, model_q[0].d);
    end else begin
      cmp("idle_addr", 32'(dmem_addr), 32'h0);
      cmp("idle_we", 32'(dmem_we), 32'h0);
      cmp("idle_din", dmem_din, 32'h0);
    end
    if (rst_n) begin
      acc = st_valid && (model_q.size() != DEPTH);
      pop = (model_q.size() != 0) && dmem_ready;
      fmt(st_addr, st_data, st_sel, bad, e);
      if (pop) void'(model_q.pop_front());
      if (acc && !bad) model_q.push_back(e);
      misal_exp = acc && bad;
    end
  end

  // One cycle of stimulus applied at the falling edge.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] s, input logic rdy, input logic [31:0] ld);
    @(negedge clk);
    st_valid = v; st_addr = a; st_data = d; st_sel = s; dmem_ready = rdy; ld_addr = ld;
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 2'd0, rdy, 32'hFFFF_FFF0);
  endtask

  initial begin
    // Reset
    rst_n = 1'b0;
    idle(1'b0, 2);
    #3;
    cmp("lit_reset_count", 32'(count), 32'h0);
    cmp("lit_reset_valid", 32'(dmem_valid), 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // SB to 0x13
    step(1'b1, 32'h0000_0013, 32'h1234_56AB, 2'd0, 1'b1, 32'hFFFF_FFF0);
    idle(1'b1, 1); #3;
    cmp("lit_sb_valid", 32'(dmem_valid), 32'h1);
    cmp("lit_sb_addr", 32'(dmem_addr), 32'h4);
    cmp("lit_sb_we", 32'(dmem_we), 32'h8);
    cmp("lit_sb_din", dmem_din, 32'hABAB_ABAB);
    idle(1'b1, 1); #3;
    cmp("lit_sb_empty", 32'(empty), 32'h1);

    // SH then SW, order and formatting
    step(1'b1, 32'h0000_0102, 32'hDEAD_BEEF, 2'd1, 1'b0, 32'hFFFF_FFF0);
    step(1'b1, 32'h0000_0104, 32'hCAFE_F00D, 2'd2, 1'b0, 32'hFFFF_FFF0);
    idle(1'b0, 1); #3;
    cmp("lit_sh_addr", 32'(dmem_addr), 32'h40);
    cmp("lit_sh_we", 32'(dmem_we), 32'hC);
    cmp("lit_sh_din", dmem_din, 32'hBEEF_BEEF);
    idle(1'b1, 1);
    idle(1'b0, 1); #3;
    cmp("lit_sw_addr", 32'(dmem_addr), 32'h41);
    cmp("lit_sw_we", 32'(dmem_we), 32'hF);
    cmp("lit_sw_din", dmem_din, 32'hCAFE_F00D);
    idle(1'b1, 2);

    // Fill with dmem stalled; fifth store waits for one pop
    for (int i = 0; i < 5; i++) step(1'b1, 32'(16 * i), 32'h1000 + 32'(i), 2'd2, 1'b0, 32'hFFFF_FFF0);
    #3;
    cmp("lit_full_count", 32'(count), 32'h4);
    cmp("lit_full_ready", 32'(st_ready), 32'h0);
    step(1'b1, 32'd64, 32'h1004, 2'd2, 1'b0, 32'hFFFF_FFF0);
    step(1'b1, 32'd64, 32'h1004, 2'd2, 1'b1, 32'hFFFF_FFF0);
    step(1'b1, 32'd64, 32'h1004, 2'd2, 1'b0, 32'hFFFF_FFF0);
    #3;
    cmp("lit_after_pop_count", 32'(count), 32'h3);
    idle(1'b0, 1); #3;
    cmp("lit_refill_count", 32'(count), 32'h4);
    idle(1'b1, 5);

    // Misaligned SW and illegal select
    step(1'b1, 32'h0000_0006, 32'h5555_5555, 2'd2, 1'b1, 32'hFFFF_FFF0);
    step(1'b1, 32'h0000_0000, 32'h6666_6666, 2'd3, 1'b1, 32'hFFFF_FFF0);
    #3;
    cmp("lit_mis1", 32'(st_misaligned), 32'h1);
    idle(1'b1, 1); #3;
    cmp("lit_mis2", 32'(st_misaligned), 32'h1);
    cmp("lit_mis_count", 32'(count), 32'h0);
    idle(1'b1, 1); #3;
    cmp("lit_mis_clear", 32'(st_misaligned), 32'h0);

    // Load hazard
    step(1'b1, 32'h0000_0201, 32'h77, 2'd0, 1'b0, 32'hFFFF_FFF0);
    step(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0000_0203); #3;
    cmp("lit_haz_hit", 32'(ld_hazard), 32'h1);
    step(1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 32'h0000_0204); #3;
    cmp("lit_haz_miss", 32'(ld_hazard), 32'h0);
    step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 32'h0000_0203); #3;
    cmp("lit_haz_popcycle", 32'(ld_hazard), 32'h1);
    step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 32'h0000_0203); #3;
    cmp("lit_haz_gone", 32'(ld_hazard), 32'h0);

    // Reset mid-drain
    for (int i = 0; i < 3; i++) step(1'b1, 32'h300 + 32'(4 * i), 32'(i), 2'd2, 1'b0, 32'hFFFF_FFF0);
    idle(1'b1, 1);
    @(negedge clk);
    rst_n = 1'b0; st_valid = 1'b0; #3;
    cmp("lit_rst_valid", 32'(dmem_valid), 32'h0);
    cmp("lit_rst_empty", 32'(empty), 32'h1);
    cmp("lit_rst_we", 32'(dmem_we), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    idle(1'b1, 3); #3;
    cmp("lit_post_rst_valid", 32'(dmem_valid), 32'h0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n      = ($urandom_range(0, 299) != 0);
      st_valid   = ($urandom_range(0, 99) < 60);
      st_addr    = {$urandom_range(0, 3) == 0 ? 16'($urandom) : 16'h0, 8'h0, 8'($urandom_range(0, 63))};
      st_data    = $urandom;
      st_sel     = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      dmem_ready = ($urandom_range(0, 99) < 45);
      ld_addr    = {16'($urandom), 8'h0, 8'($urandom_range(0, 63))};
    end
    @(negedge clk); rst_n = 1'b1; st_valid = 1'b0;
    idle(1'b1, 8);
    @(negedge clk); #4;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
